// File: rtl/reg_delay_pkg.sv
// reg_delay_pkg: shared types and helpers for the runtime-programmable delay
// controller.
//   DLY_W     : width of every delay / occupancy quantity
//   state_e   : reconfiguration FSM states
//   clamp_dly : limits a requested delay to the deepest implemented tap
package reg_delay_pkg;

    localparam int DLY_W = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        APPLY = 2'd2
    } state_e;

    function automatic logic [DLY_W-1:0] clamp_dly(input logic [DLY_W-1:0] d,
                                                   input int max_dly);
        if (int'(d) > max_dly) return DLY_W'(max_dly);
        return d;
    endfunction

endpackage

// File: rtl/vld_delay_chain.sv
// vld_delay_chain: MAX_DLY-stage shift chain of {valid, data} with a tap mux.
//   clk, rst : clock, async active-high reset (clears all stages)
//   clr      : synchronous clear of every valid bit
//   in_vld   : valid bit loaded into stage 1
//   in_dat   : data loaded into stage 1
//   dly      : tap select; 0 bypasses the chain combinationally
//   tap_vld  : valid at the selected tap
//   tap_dat  : data at the selected tap, zero when tap_vld is low
module vld_delay_chain
    import reg_delay_pkg::*;
#(
    parameter int REG_WIDTH = 8,
    parameter int MAX_DLY   = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 in_vld,
    input  logic [REG_WIDTH-1:0] in_dat,
    input  logic [DLY_W-1:0]     dly,
    output logic                 tap_vld,
    output logic [REG_WIDTH-1:0] tap_dat
);

    logic [MAX_DLY:1]                vld_q;
    logic [MAX_DLY:1][REG_WIDTH-1:0] dat_q;

    // Chain shifts every cycle regardless of downstream state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            dat_q <= '0;
        end else begin
            for (int k = MAX_DLY; k >= 2; k--) begin
                vld_q[k] <= vld_q[k-1];
                dat_q[k] <= dat_q[k-1];
            end
            vld_q[1] <= in_vld;
            dat_q[1] <= in_dat;
            if (clr) vld_q <= '0;
        end
    end

    always_comb begin
        tap_vld = 1'b0;
        tap_dat = '0;
        if (dly == '0) begin
            tap_vld = in_vld;
            tap_dat = in_dat;
        end else begin
            for (int k = 1; k <= MAX_DLY; k++) begin
                if (dly == DLY_W'(k)) begin
                    tap_vld = vld_q[k];
                    tap_dat = dat_q[k];
                end
            end
        end
        if (!tap_vld) tap_dat = '0;
    end

endmodule

// File: rtl/reg_delay_ctrl.sv
// reg_delay_ctrl: runtime-programmable delay line. A new delay is applied only
// after all samples in flight at the old delay have left the tap, so no sample
// is dropped, duplicated or emitted at a mixed delay.
//   clk, rst         : clock, async active-high reset
//   cfg_dly, cfg_wr  : requested delay (clamped to MAX_DLY) and its strobe
//   cfg_busy         : reconfiguration in progress, cfg_wr ignored
//   cfg_ack          : one-cycle pulse when a requested delay takes effect
//   cur_dly          : active delay
//   in_vld, in_rdy   : producer handshake
//   reg_in           : input data
//   out_vld, reg_out : delayed sample, reg_out zero when not valid
module reg_delay_ctrl
    import reg_delay_pkg::*;
#(
    parameter int REG_WIDTH   = 8,
    parameter int MAX_DLY     = 31,
    parameter int DEFAULT_DLY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DLY_W-1:0]     cfg_dly,
    input  logic                 cfg_wr,
    output logic                 cfg_busy,
    output logic                 cfg_ack,
    output logic [DLY_W-1:0]     cur_dly,
    input  logic                 in_vld,
    output logic                 in_rdy,
    input  logic [REG_WIDTH-1:0] reg_in,
    output logic                 out_vld,
    output logic [REG_WIDTH-1:0] reg_out
);

    state_e           state_q, state_d;
    logic [DLY_W-1:0] cur_dly_q, pend_q, occ_q, occ_d, cfg_c;
    logic             same_ack_q, rdy_en_q;
    logic             run, accept, apply, wr_same, wr_diff;

    assign run     = (state_q == RUN);
    assign apply   = (state_q == APPLY);
    // rdy_en_q holds in_rdy low until the first edge after reset release.
    assign in_rdy  = run & rdy_en_q;
    assign accept  = in_vld & in_rdy;
    assign cfg_c   = clamp_dly(cfg_dly, MAX_DLY);
    assign wr_same = run & cfg_wr & (cfg_c == cur_dly_q);
    assign wr_diff = run & cfg_wr & (cfg_c != cur_dly_q);

    assign cfg_busy = ~run;
    assign cfg_ack  = apply | same_ack_q;
    assign cur_dly  = cur_dly_q;

    // At delay 0 accept and out_vld coincide, so occ stays at zero.
    assign occ_d = occ_q + DLY_W'(accept) - DLY_W'(out_vld);

    vld_delay_chain #(
        .REG_WIDTH(REG_WIDTH),
        .MAX_DLY  (MAX_DLY)
    ) u_chain (
        .clk    (clk),
        .rst    (rst),
        .clr    (apply),
        .in_vld (accept),
        .in_dat (reg_in),
        .dly    (cur_dly_q),
        .tap_vld(out_vld),
        .tap_dat(reg_out)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (wr_diff) state_d = DRAIN;
            DRAIN:   if (occ_d == '0) state_d = APPLY;
            APPLY:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            cur_dly_q  <= DLY_W'(DEFAULT_DLY);
            pend_q     <= '0;
            occ_q      <= '0;
            same_ack_q <= 1'b0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            same_ack_q <= wr_same;
            rdy_en_q   <= 1'b1;
            occ_q      <= apply ? '0 : occ_d;
            if (wr_diff) pend_q <= cfg_c;
            if (apply) cur_dly_q <= pend_q;
        end
    end

endmodule
